// File: rtl/scan_select_seq_pkg.sv
// Shared types and constants for the scan select sequencer: state encoding,
// first/last select codes and the select stepping helpers.
package scan_select_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_FIRST_UP = 2'd0;
  localparam logic [1:0] SEL_FIRST_DN = 2'd3;

  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic down);
    return down ? cur - 2'd1 : cur + 2'd1;
  endfunction

  // The terminal code of a sweep is the first code of the opposite direction.
  function automatic logic [1:0] last_sel(input logic down);
    return down ? SEL_FIRST_UP : SEL_FIRST_DN;
  endfunction

endpackage

// File: rtl/scan_select_seq_dwell_counter.sv
// Dwell counter: counts enabled cycles from 0 up to limit and raises a
// registered terminal flag while the count equals limit.
module scan_select_seq_dwell_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] limit,
  output logic             tc
);

  logic [DIV_W-1:0] count;

  // tc is computed one cycle ahead so the FSM sees it as a flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tc    <= (limit == '0);
    end else if (enable) begin
      if (tc) begin
        count <= '0;
        tc    <= (limit == '0);
      end else begin
        count <= count + DIV_W'(1);
        tc    <= ((count + DIV_W'(1)) == limit);
      end
    end
  end

endmodule

// File: rtl/scan_select_seq.sv
// Scan select sequencer: steps a 2-bit decoder select through 0..3 or 3..0,
// holding each code for div+1 enabled cycles, single sweep or continuous.
module scan_select_seq
  import scan_select_seq_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             mode_cont,
  input  logic             dir_down,
  input  logic [DIV_W-1:0] div,
  output logic [1:0]       sel,
  output logic             sel_valid,
  output logic             step,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  state_t           state;
  logic [DIV_W-1:0] div_l;
  logic             dir_l;
  logic             cont_l;
  logic             tc;
  logic             cnt_clear;
  logic             cnt_en;
  logic [DIV_W-1:0] cnt_limit;

  assign dbg_state = state;
  assign cnt_clear = (state == ST_IDLE) && start;
  assign cnt_en    = (state != ST_IDLE) && !stop && en;
  assign cnt_limit = (state == ST_IDLE) ? div : div_l;

  scan_select_seq_dwell_counter #(.DIV_W(DIV_W)) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (cnt_limit),
    .tc     (tc)
  );

  // sel_valid qualifies sel; there is no ready, the decoder consumes every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= SEL_FIRST_UP;
      sel_valid <= 1'b0;
      step      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_l     <= '0;
      dir_l     <= 1'b0;
      cont_l    <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_l     <= div;
            dir_l     <= dir_down;
            cont_l    <= mode_cont;
            sel       <= dir_down ? SEL_FIRST_DN : SEL_FIRST_UP;
            state     <= en ? ST_RUN : ST_PAUSE;
            busy      <= 1'b1;
            sel_valid <= 1'b1;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (stop) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            sel_valid <= 1'b0;
          end else if (!en) begin
            state <= ST_PAUSE;
          end else begin
            state <= ST_RUN;
            if (tc) begin
              if (!cont_l && (sel == last_sel(dir_l))) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                sel_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                sel  <= next_sel(sel, dir_l);
                step <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
